axi_read_arbiter: RTL
=====================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, AXI address width.
REQ-002 Parameter DATA_W, default 64, AXI read data width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 s_arvalid  in  2  read request valid per requester; index 0 = instruction cache, 1 = data cache.
REQ-006 s_araddr  in  2 x ADDR_W  per-requester burst start address.
REQ-007 s_arlen  in  2 x 8  per-requester burst length (beats minus 1).
REQ-008 s_arready  out  2  per-requester address-accepted pulse.
REQ-009 s_rvalid  out  2  per-requester read beat valid.
REQ-010 s_rdata  out  DATA_W  read beat data, shared by both requesters.
REQ-011 s_rlast  out  1  last beat of burst, shared.
REQ-012 s_rready  in  2  per-requester beat accept.
REQ-013 instruction_cache_reading  out  1  instruction cache owns the AXI read channel.
REQ-014 data_cache_reading  out  1  data cache owns the AXI read channel.
REQ-015 m_axi_arvalid, m_axi_araddr[ADDR_W], m_axi_arlen[8], m_axi_arsize[3], m_axi_arburst[2]  out  AXI read address channel.
REQ-016 m_axi_arready  in  1; m_axi_rvalid  in  1; m_axi_rdata  in  DATA_W; m_axi_rlast  in  1  AXI read data inputs.
REQ-017 m_axi_rready  out  1  AXI read data accept.

Function
REQ-018 FSM states SHALL be IDLE, ADDR and DATA; one burst is outstanding at a time.
REQ-019 IDLE: if any s_arvalid is set in cycle N, winner selected (REQ-030), its araddr/arlen latched, FSM enters ADDR in N+1.
REQ-020 ADDR: m_axi_arvalid=1, araddr/arlen taken from latched copy, arsize=3'b011, arburst=2'b01 (INCR).
REQ-021 ADDR: on m_axi_arready=1, s_arready[owner] pulses 1 for that single cycle and the FSM enters DATA.
REQ-022 DATA: s_rvalid[owner]=m_axi_rvalid, s_rvalid[other]=0, m_axi_rready=s_rready[owner], s_rdata/s_rlast pass through combinationally.
REQ-023 DATA: a beat with m_axi_rvalid & m_axi_rready & m_axi_rlast completes the burst; FSM returns to IDLE next cycle.
REQ-024 Ownership flag of owner is 1 from ADDR entry through the rlast handshake cycle inclusive; both flags are 0 in IDLE; the two flags are never 1 together.
REQ-025 Minimum one IDLE cycle between bursts; arbitration occurs only in IDLE.
REQ-026 Requests arriving during ADDR/DATA wait; a requester dropping s_arvalid before s_arready is an AXI violation, but the latched burst still completes.
REQ-027 rvalid without rlast continues DATA indefinitely; a beat with rvalid=1 and rready=0 is held and not counted.
REQ-028 Outputs outside ADDR/DATA: m_axi_arvalid=0, m_axi_rready=0, s_arready=0, s_rvalid=0.

Reset
REQ-029 reset low SHALL force IDLE, clear owner, latched address/length and last-winner, and set every output listed in REQ-028 and REQ-024 to 0 immediately, including mid-burst; an in-flight external burst is not drained.

Configuration
REQ-030 Macro AXI_ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the requester not granted last (last-winner resets to instruction cache, so the first tie goes to the data cache); undefined: the data cache always wins ties; a single request is always granted either way.

Structure
REQ-031 Package axi_arb_pkg SHALL hold the FSM state enum, REQ_IC=0, REQ_DC=1, AXI_SIZE_8B=3'b011 and AXI_BURST_INCR=2'b01.
REQ-032 Winner selection SHALL be sub-module arb_select (inputs: requests, last-winner; output: winner index).

Verification
REQ-033 Single instruction-cache request: s_arvalid=01, addr 0x1000, arlen 7 -> m_axi_araddr=0x1000 one cycle later, 8 beats reach s_rvalid[0] only, instruction_cache_reading falls after rlast.
REQ-034 Simultaneous requests, IC 0x2000 and DC 0x3000 -> data cache is served first in both builds; with the macro defined the next tie goes to the instruction cache, without it the data cache wins again.
REQ-035 arready held low 5 cycles -> m_axi_arvalid and address stable, s_arready pulses exactly once on acceptance.
REQ-036 Owner deasserts s_rready on beat 3 of 8 -> m_axi_rready=0, beat held, no beat lost or duplicated.
REQ-037 reset asserted during beat 4 of a data-cache burst -> all outputs 0 that cycle, next request after release is granted cleanly.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the two-requester AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic       REQ_IC         = 1'b0;
  localparam logic       REQ_DC         = 1'b1;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_read_arbiter_arb_select.sv
// Picks which requester wins the read channel. Tie policy depends on
// AXI_ARB_ROUND_ROBIN_EN (defined: alternate; undefined: data cache wins).
module arb_select
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       winner
);

  always_comb begin
    winner = REQ_DC;
    if (req == 2'b01) begin
      winner = REQ_IC;
    end else if (req == 2'b10) begin
      winner = REQ_DC;
    end else if (req == 2'b11) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
      winner = ~last_winner;
`else
      winner = REQ_DC;
`endif
    end
  end

`ifndef AXI_ARB_ROUND_ROBIN_EN
  // Fixed-priority build has no use for history.
  logic unused_last;
  assign unused_last = last_winner;
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between instruction and data caches, one burst
// at a time. Optional macro: AXI_ARB_ROUND_ROBIN_EN (round-robin ties).
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             s_arvalid,
  input  logic [1:0][ADDR_W-1:0] s_araddr,
  input  logic [1:0][7:0]        s_arlen,
  output logic [1:0]             s_arready,
  output logic [1:0]             s_rvalid,
  output logic [DATA_W-1:0]      s_rdata,
  output logic                   s_rlast,
  input  logic [1:0]             s_rready,
  output logic                   instruction_cache_reading,
  output logic                   data_cache_reading,
  output logic                   m_axi_arvalid,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  input  logic                   m_axi_arready,
  input  logic                   m_axi_rvalid,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic                   m_axi_rlast,
  output logic                   m_axi_rready
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              winner;
  logic              in_addr, in_data;

  arb_select u_arb_select (
    .req         (s_arvalid),
    .last_winner (last_q),
    .winner      (winner)
  );

  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|s_arvalid) begin
          owner_d = winner;
          last_d  = winner;
          addr_d  = s_araddr[winner];
          len_d   = s_arlen[winner];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IC;
      last_q  <= REQ_IC;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  assign m_axi_arvalid = in_addr;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_rready  = in_data & s_rready[owner_q];

  // Data is shared; only the owner's valid is raised, so rdata needs no mux.
  assign s_rdata = m_axi_rdata;
  assign s_rlast = in_data & m_axi_rlast;

  for (genvar g = 0; g < 2; g++) begin : g_req
    localparam logic IDX = 1'(g);
    assign s_arready[g] = in_addr & m_axi_arready & (owner_q == IDX);
    assign s_rvalid[g]  = in_data & m_axi_rvalid & (owner_q == IDX);
  end

  assign instruction_cache_reading = (in_addr | in_data) & (owner_q == REQ_IC);
  assign data_cache_reading        = (in_addr | in_data) & (owner_q == REQ_DC);

endmodule
